tx_pattern_gen: RTL and testbench

Parametrised parallel TX test-pattern source. It replaces the fixed bank of per-bit PRBS generators feeding the 16:4 serializer mux. Each enabled cycle it produces one WIDTH-bit word from a selectable PRBS polynomial, a user word, or a clock pattern. Error injection uses a req/ack handshake, injected errors are counted, and the LFSR recovers automatically from an all-zero lock-up state.

---
 rtl/tx_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_tx_pattern_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pattern_gen.sv
// Parallel TX test-pattern source: PRBS7/15/31, user word or clock pattern, one WIDTH-bit word
// per enabled cycle, with handshaked single-bit error injection and LFSR zero-state recovery.
module tx_pattern_gen #(
   parameter int WIDTH     = 16,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cke_i,
   input  logic [2:0]           mode_i,
   input  logic [WIDTH-1:0]     user_word_i,
   input  logic                 inv_i,
   input  logic                 inj_req_i,
   output logic                 inj_ack_o,
   output logic [WIDTH-1:0]     dout_o,
   output logic                 dout_valid_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic                 lockup_o
);

   typedef enum logic {SEED, RUN} state_t;

   state_t                 state_q;
   logic [30:0]            s_q, s_d;
   logic [2:0]             mode_q;
   logic [WIDTH-1:0]       dout_q, word_d;
   logic                   dout_valid_q;
   logic                   inj_ack_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;
   logic                   lockup_q;
   logic                   armed_q;
   logic                   lock_hit;
   logic                   accept;

   // Fully unrolled serial LFSR: bit k of the word is the k-th emitted bit.
   always_comb begin
      s_d      = s_q;
      word_d   = '0;
      lock_hit = 1'b0;
      case (mode_q)
         3'd0: begin
            if (s_q[6:0] == '0) begin
               lock_hit = 1'b1;
               s_d      = '1;
            end else begin
               for (int k = 0; k < WIDTH; k++) begin
                  s_d       = {s_d[29:0], s_d[6] ^ s_d[5]};
                  word_d[k] = s_d[0];
               end
            end
         end
         3'd1: begin
            if (s_q[14:0] == '0) begin
               lock_hit = 1'b1;
               s_d      = '1;
            end else begin
               for (int k = 0; k < WIDTH; k++) begin
                  s_d       = {s_d[29:0], s_d[14] ^ s_d[13]};
                  word_d[k] = s_d[0];
               end
            end
         end
         3'd2: begin
            if (s_q == '0) begin
               lock_hit = 1'b1;
               s_d      = '1;
            end else begin
               for (int k = 0; k < WIDTH; k++) begin
                  s_d       = {s_d[29:0], s_d[30] ^ s_d[27]};
                  word_d[k] = s_d[0];
               end
            end
         end
         3'd3: word_d = user_word_i;
         3'd4: begin
            for (int k = 0; k < WIDTH; k++) begin
               word_d[k] = ((k % 2) == 1);
            end
         end
         default: word_d = '0;
      endcase
   end

   assign accept = inj_req_i && armed_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= SEED;
         s_q          <= '1;
         mode_q       <= mode_i;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         inj_ack_q    <= 1'b0;
         err_cnt_q    <= '0;
         lockup_q     <= 1'b0;
         armed_q      <= 1'b1;
      end else if (!cke_i) begin
         inj_ack_q <= 1'b0;
      end else begin
         inj_ack_q <= 1'b0;
         if (!inj_req_i) armed_q <= 1'b1;
         case (state_q)
            SEED: begin
               s_q          <= '1;
               mode_q       <= mode_i;
               dout_q       <= '0;
               dout_valid_q <= 1'b0;
               state_q      <= RUN;
            end
            RUN: begin
               if (mode_i != mode_q) begin
                  // Mode change acts as a one-cycle reseed; RUN resumes next cycle.
                  mode_q       <= mode_i;
                  s_q          <= '1;
                  dout_q       <= '0;
                  dout_valid_q <= 1'b0;
               end else begin
                  s_q          <= s_d;
                  dout_q       <= word_d ^ {WIDTH{inv_i}} ^ WIDTH'(accept);
                  dout_valid_q <= 1'b1;
                  if (lock_hit) lockup_q <= 1'b1;
                  if (accept) begin
                     inj_ack_q <= 1'b1;
                     armed_q   <= 1'b0;
                     if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                  end
               end
            end
            default: state_q <= SEED;
         endcase
      end
   end

   assign inj_ack_o    = inj_ack_q;
   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign err_cnt_o    = err_cnt_q;
   assign lockup_o     = lockup_q;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Bench for tx_pattern_gen: recurrence-based sequence model x[t] = x[t-a] ^ x[t-b] plus a
// cycle-level model of seeding, injection, gating and recovery; directed and random steps.
module tb_tx_pattern_gen;
   localparam int W  = 16;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst, cke, inv, inj_req;
   logic [2:0]    mode;
   logic [W-1:0]  user_word;
   logic          inj_ack, dout_valid, lockup;
   logic [W-1:0]  dout;
   logic [CW-1:0] err_cnt;

   always #5 clk = ~clk;

   tx_pattern_gen #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .cke_i(cke), .mode_i(mode), .user_word_i(user_word),
      .inv_i(inv), .inj_req_i(inj_req), .inj_ack_o(inj_ack), .dout_o(dout),
      .dout_valid_o(dout_valid), .err_cnt_o(err_cnt), .lockup_o(lockup)
   );

   int total = 0;
   int bad   = 0;

   bit           hist[$];
   bit           m_run, m_valid, m_ack, m_lock, m_armed;
   logic [2:0]   m_mode;
   logic [W-1:0] m_dout, m_pat;
   int           m_cnt, acks;
   logic [W-1:0] mw[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic seed();
      hist.delete();
      repeat (31) hist.push_back(1'b1);
   endtask

   task automatic gen_word(output logic [W-1:0] w, output bit lk);
      int a, b;
      bit z, nb;
      lk = 1'b0;
      w  = '0;
      a  = 0;
      b  = 0;
      case (m_mode)
         3'd0: begin a = 7;  b = 6;  end
         3'd1: begin a = 15; b = 14; end
         3'd2: begin a = 31; b = 28; end
         3'd3: w = user_word;
         3'd4: for (int k = 0; k < W; k++) w[k] = ((k % 2) == 1);
         default: w = '0;
      endcase
      if (a != 0) begin
         z = 1'b1;
         for (int i = 1; i <= a; i++) if (hist[hist.size()-i]) z = 1'b0;
         if (z) begin
            lk = 1'b1;
            seed();
         end else begin
            for (int k = 0; k < W; k++) begin
               nb = hist[hist.size()-a] ^ hist[hist.size()-b];
               w[k] = nb;
               hist.push_back(nb);
               void'(hist.pop_front());
            end
         end
      end
   endtask

   task automatic model_edge();
      logic [W-1:0] w;
      bit lk, acc;
      m_ack = 1'b0;
      if (rst) begin
         seed();
         m_run = 1'b0; m_mode = mode; m_dout = '0; m_valid = 1'b0;
         m_cnt = 0; m_lock = 1'b0; m_armed = 1'b1;
      end else if (cke) begin
         if (!m_run || mode != m_mode) begin
            m_run = 1'b1; m_mode = mode; seed();
            m_dout = '0; m_valid = 1'b0;
         end else begin
            gen_word(w, lk);
            acc = inj_req && m_armed;
            if (lk) m_lock = 1'b1;
            m_pat   = w ^ {W{inv}};
            m_dout  = m_pat ^ W'(acc);
            m_valid = 1'b1;
            if (m_mode == 3'd0) mw.push_back(w);
            if (acc) begin
               m_ack = 1'b1; m_armed = 1'b0;
               if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
         end
         if (!inj_req) m_armed = 1'b1;
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      chk("dout", dout, m_dout);
      chk("dout_valid", dout_valid, m_valid);
      chk("inj_ack", inj_ack, m_ack);
      chk("err_cnt", err_cnt, m_cnt);
      chk("lockup", lockup, m_lock);
      if (inj_ack) acks++;
      if (m_ack) chk("inj_bit0_only", dout ^ m_pat, 1);
   endtask

   logic [2:0] mlist [5];

   initial begin
      mlist = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
      rst = 1'b1; cke = 1'b1; mode = 3'd0; user_word = '0; inv = 1'b0; inj_req = 1'b0; acks = 0;

      // Reset and PRBS7 latency / first word / period
      cyc(); cyc();
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      rst = 1'b0;
      cyc();
      chk("lat1_valid", dout_valid, 0);
      cyc();
      chk("lat2_valid", dout_valid, 1);
      chk("prbs7_first", dout[7:0], 8'h40);
      for (int i = 0; i < 300; i++) begin
         cyc();
         if (mw.size() > 127) chk("prbs7_period", dout, mw[mw.size()-1-127]);
      end

      // Mode coverage
      user_word = 16'hA5C3;
      for (int m = 0; m < 5; m++) begin
         mode = mlist[m];
         cyc();
         chk("chg_valid", dout_valid, 0);
         chk("chg_dout", dout, 0);
         repeat (20) cyc();
         case (mlist[m])
            3'd3: chk("user_word", dout, 16'hA5C3);
            3'd4: chk("clock_word", dout, 16'hAAAA);
            3'd6: chk("zero_word", dout, 16'h0000);
            default: chk("prbs_valid", dout_valid, 1);
         endcase
      end

      // Error injection in PRBS31
      mode = 3'd2;
      repeat (3) cyc();
      acks = 0;
      inj_req = 1'b1; repeat (10) cyc();
      inj_req = 1'b0; cyc();
      inj_req = 1'b1; cyc();
      inj_req = 1'b0; repeat (3) cyc();
      chk("ack_count", acks, 2);
      chk("err_cnt_two", err_cnt, 2);

      // Random cke gating in PRBS15, then a deferred mode change
      mode = 3'd1;
      repeat (2) cyc();
      for (int i = 0; i < 500; i++) begin
         cke = 1'($urandom % 2);
         cyc();
      end
      cke = 1'b1; cyc(); cyc();
      cke = 1'b0; mode = 3'd0;
      repeat (3) cyc();
      chk("defer_hold_valid", dout_valid, 1);
      cke = 1'b1;
      cyc();
      chk("defer_chg_valid", dout_valid, 0);
      cyc();

      // Random user words, polarity and gating
      mode = 3'd3;
      repeat (2) cyc();
      for (int i = 0; i < 40; i++) begin
         user_word = W'($urandom);
         inv       = 1'($urandom % 2);
         cke       = ($urandom % 4) != 0;
         cyc();
      end
      inv = 1'b0; cke = 1'b1;

      // Saturation and inv
      mode = 3'd2; rst = 1'b1; cyc();
      rst = 1'b0; cyc(); cyc();
      for (int i = 0; i < 5; i++) begin
         inj_req = 1'b1; cyc();
         inj_req = 1'b0; cyc();
      end
      chk("err_cnt_sat", err_cnt, 3);
      mode = 3'd3; user_word = 16'h00FF;
      cyc(); cyc();
      chk("inv_off", dout, 16'h00FF);
      inv = 1'b1;
      cyc();
      chk("inv_on", dout, 16'hFF00);
      inv = 1'b0;

      // Zero-state recovery
      mode = 3'd0;
      repeat (6) cyc();
      dut.s_q = '0;
      foreach (hist[i]) hist[i] = 1'b0;
      cyc();
      chk("lock_word", dout, 0);
      chk("lock_flag", lockup, 1);
      cyc();
      chk("reseed_word", dout[7:0], 8'h40);
      repeat (3) cyc();
      chk("lock_sticky", lockup, 1);
      rst = 1'b1; cyc();
      chk("lock_clear", lockup, 0);
      rst = 1'b0;
      repeat (3) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
